servant_spi_mem_responder: RTL
==============================

Name: servant_spi_mem_responder

Overview:
- SPI mode-0 responder (target) that serves an SPI memory protocol from a byte-wide synchronous RAM. Pairs with the servant SPI master interface.
- All logic runs in the wb_clk domain. SCK, SS and MOSI are oversampled through synchronizers.
- Decodes READ/WRITE commands and a 3-byte big-endian address, then streams data bytes with address auto-increment.
- Used in the FRAM/SPI bring-up build and in simulation as the CPU's instruction/data memory behind the SPI link.

Parameters:
- ADDRESS_WIDTH, 18, RAM address bits used. The low ADDRESS_WIDTH bits of the 24-bit SPI address are kept; upper bits are ignored.
- OP_READ, 8'h03, read opcode.
- OP_WRITE, 8'h02, write opcode.

Ports:
- wb_clk  in  1  system clock; all state is on the rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock from master, CPOL=0. Requires SCK high and low times of at least 4 wb_clk cycles each.
- spi_ss  in  1  chip select, active low.
- spi_mosi  in  1  master-to-responder data, MSB first.
- spi_miso  out  1  responder-to-master data. Driven 0 when SS is high or when no read is active.
- o_ram_addr  out  ADDRESS_WIDTH  RAM byte address.
- o_ram_wdata  out  8  RAM write data.
- o_ram_we  out  1  one-cycle write strobe.
- o_ram_re  out  1  one-cycle read strobe. i_ram_rdata is valid exactly 1 cycle later.
- i_ram_rdata  in  8  RAM read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Synchronization: each of SCK, SS and MOSI passes through a 2-flop synchronizer. SCK rise/fall pulses come from a third register stage. MOSI is sampled on the detected rise.
- SS high (synchronized) in any state:
  - next cycle: state returns to IDLE, bit counter clears, MISO goes to 0;
  - a partial write byte is discarded (no o_ram_we);
  - an in-flight o_ram_re still completes, but its data is dropped.
- IDLE: on SS low, go to CMD.
- CMD: shift 8 bits.
  - On the 8th rise: OP_READ goes to ADDR(read); OP_WRITE goes to ADDR(write); any other opcode goes to IGNORE.
- ADDR: shift 24 bits MSB first. o_ram_addr holds addr[ADDRESS_WIDTH-1:0].
  - On the 24th rise, read mode: pulse o_ram_re with that address, capture i_ram_rdata into the tx buffer the next cycle, then go to RDATA.
  - On the 24th rise, write mode: go to WDATA.
- RDATA:
  - Each SCK fall that starts a byte loads the tx buffer into the shift register and drives bit 7 on MISO. The other 7 falls shift the register left.
  - The 8th rise of each byte increments the address and pulses o_ram_re for the new address. The buffer is refilled before the next fall.
- WDATA:
  - The 8th rise of each byte pulses o_ram_we for one cycle, with o_ram_addr equal to the current address and o_ram_wdata equal to the assembled byte.
  - The address increments on the following cycle.
- IGNORE: MISO stays 0 and MOSI is discarded until SS goes high.
- Address increment wraps modulo 2^ADDRESS_WIDTH (all-ones goes to 0).
- o_ram_we and o_ram_re are never asserted in the same cycle.
- Latency:
  - write: o_ram_we fires 3–4 wb_clk cycles after the 8th SCK rise at the pin (synchronizer delay plus edge detect);
  - read: first data bit is on MISO 3–4 cycles after the first data-phase SCK fall at the pin.

Optional Feature:
- Macro SPI_RESP_WEL_EN.
- Defined: adds a write-enable latch (WEL), reset value 0.
  - 8'h06 (WREN) sets WEL at SS rise.
  - 8'h04 (WRDI) clears WEL at SS rise.
  - 8'h05 (RDSR) enters STATUS state and repeatedly returns {6'b0, WEL, 1'b0} on MISO until SS rises.
  - WRITE with WEL=0 completes the protocol but suppresses o_ram_we.
  - WEL clears at the SS rise that ends any WRITE transaction.
- Undefined: WRITE is always effective; opcodes 0x04, 0x05 and 0x06 go to IGNORE.

Decomposition:
- Package servant_spi_resp_pkg holds:
  - opcode localparams (READ, WRITE, WREN, WRDI, RDSR);
  - state enum (IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE);
  - ADDR_BITS = 24.
- One sub-module, servant_spi_resp_sync: 2-flop synchronizer plus edge detect. Outputs sck_rise, sck_fall, ss_n_sync and mosi_sync.

Test Plan:
- WRITE 0x02, addr 0x000010, data A5 3C, then SS high → o_ram_we at 0x10=0xA5 and 0x11=0x3C; exactly 2 strobes.
- Preload RAM 0x20=0x12, 0x21=0x34; READ 0x03, addr 0x000020, 16 clocks → MISO returns 0x12 then 0x34.
- WRITE at addr 0x03FFFF (ADDRESS_WIDTH=18), data 11 22 → writes land at 0x3FFFF and 0x00000.
- WRITE with SS raised after 5 data bits → no o_ram_we; next READ works normally.
- Opcode 0xFF followed by 32 clocks → MISO constantly 0; no RAM strobes.
- With SPI_RESP_WEL_EN defined:
  - WRITE without WREN → no o_ram_we;
  - WREN, then RDSR → 0x02;
  - WRITE → strobe fires;
  - RDSR → 0x00.

Source files
------------

// File: rtl/servant_spi_resp_pkg.sv
// servant_spi_resp_pkg
// Shared definitions for the SPI memory responder: opcode values, the
// protocol state encoding and the width of the on-the-wire address field.
// Optional feature macro: SPI_RESP_WEL_EN (write-enable latch plus the
// WREN/WRDI/RDSR opcodes); the package content is the same either way.
package servant_spi_resp_pkg;

  // Width of the address field carried on the SPI link (always 3 bytes)
  localparam int ADDR_BITS = 24;

  // Opcodes understood by the responder
  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_WREN  = 8'h06;
  localparam logic [7:0] OPC_WRDI  = 8'h04;
  localparam logic [7:0] OPC_RDSR  = 8'h05;

  // Protocol phase of the current transaction
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    STATUS,
    IGNORE
  } state_e;

endpackage

// File: rtl/servant_spi_resp_sync.sv
// servant_spi_resp_sync
// Brings the asynchronous SPI pins into the clk domain. SCK, SS_N and MOSI
// each pass through two flops; a third SCK stage provides the previous
// value for rise/fall detection. MOSI has the same depth as SCK, so
// mosi_sync is aligned with the cycle in which sck_rise is reported.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   sck/ss_n/mosi - raw SPI pins
//   sck_rise/sck_fall - one-cycle pulses on synchronized SCK edges
//   ss_n_sync, mosi_sync - synchronized chip select and data
module servant_spi_resp_sync
  import servant_spi_resp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_n_sync,
  output logic mosi_sync
);

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic ss_meta_q, ss_sync_q;
  logic mosi_meta_q, mosi_sync_q;

  // Chip select resets to the deasserted level so that leaving reset never
  // looks like the start of a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      ss_meta_q   <= ss_n;
      ss_sync_q   <= ss_meta_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise  = sck_sync_q & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q & sck_prev_q;
  assign ss_n_sync = ss_sync_q;
  assign mosi_sync = mosi_sync_q;

endmodule

// File: rtl/servant_spi_mem_responder.sv
// servant_spi_mem_responder
// SPI mode-0 target serving READ/WRITE commands with a 3-byte big-endian
// address from a byte-wide synchronous RAM, with address auto-increment.
// Optional macro SPI_RESP_WEL_EN adds a write-enable latch with the
// WREN/WRDI/RDSR opcodes; without it every WRITE is effective.
// Ports:
//   wb_clk, wb_rst_n            - system clock, async active-low reset
//   spi_sck, spi_ss, spi_mosi   - SPI inputs from the master
//   spi_miso                    - SPI data back to the master
//   o_ram_addr/o_ram_wdata      - RAM byte address and write data
//   o_ram_we/o_ram_re           - one-cycle write/read strobes
//   i_ram_rdata                 - RAM read data, valid one cycle after o_ram_re
module servant_spi_mem_responder
  import servant_spi_resp_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 18,
  parameter logic [7:0] OP_READ       = OPC_READ,
  parameter logic [7:0] OP_WRITE      = OPC_WRITE
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic                     spi_sck,
  input  logic                     spi_ss,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
  output logic [7:0]               o_ram_wdata,
  output logic                     o_ram_we,
  output logic                     o_ram_re,
  input  logic [7:0]               i_ram_rdata
);

  logic sck_rise, sck_fall, ss_n_sync, mosi_sync;

  servant_spi_resp_sync u_sync (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .sck       (spi_sck),
    .ss_n      (spi_ss),
    .mosi      (spi_mosi),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .ss_n_sync (ss_n_sync),
    .mosi_sync (mosi_sync)
  );

  state_e                   state_q, state_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     is_read_q, is_read_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               tx_buf_q, tx_buf_d;
  logic [7:0]               tx_shift_q, tx_shift_d;
  logic                     miso_q, miso_d;
  logic                     re_q, re_d;
  logic                     we_q, we_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     rd_pend_q, rd_pend_d;
  logic                     inc_pend_q, inc_pend_d;
  logic [7:0]               byte_in;
  logic [7:0]               tx_src;
  logic                     write_ok;
`ifdef SPI_RESP_WEL_EN
  logic                     wel_q, wel_d;
  logic [7:0]               op_q, op_d;
`endif

  // Byte completed by the current rise, and the byte presented at the start
  // of each outgoing MISO byte (status register in STATUS state).
  assign byte_in = {shift_q[6:0], mosi_sync};
`ifdef SPI_RESP_WEL_EN
  assign tx_src   = (state_q == STATUS) ? {6'b0, wel_q, 1'b0} : tx_buf_q;
  assign write_ok = wel_q;
`else
  assign tx_src   = tx_buf_q;
  assign write_ok = 1'b1;
`endif

  // Next-state logic for the whole protocol. Chip select deassertion has
  // priority over any SCK activity so a partial byte never reaches the RAM.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    tx_buf_d   = tx_buf_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    re_d       = 1'b0;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    rd_pend_d  = re_q;
    inc_pend_d = 1'b0;
`ifdef SPI_RESP_WEL_EN
    wel_d      = wel_q;
    op_d       = op_q;
`endif

    // RAM data arrives one cycle after the read strobe; it is dropped if the
    // transaction has already ended.
    if (rd_pend_q && !ss_n_sync) tx_buf_d = i_ram_rdata;
    if (inc_pend_q) addr_d = addr_q + 1'b1;

    if (ss_n_sync) begin
      state_d   = IDLE;
      bit_cnt_d = 5'd0;
      miso_d    = 1'b0;
`ifdef SPI_RESP_WEL_EN
      // Latch updates take effect once, at the end of the transaction.
      if (state_q != IDLE) begin
        if (op_q == OPC_WREN) wel_d = 1'b1;
        else if (op_q == OPC_WRDI || op_q == OP_WRITE) wel_d = 1'b0;
      end
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = 5'd0;
`ifdef SPI_RESP_WEL_EN
          op_d      = 8'h00;
`endif
        end
        CMD: begin
          if (sck_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
`ifdef SPI_RESP_WEL_EN
              op_d      = byte_in;
`endif
              if (byte_in == OP_READ) begin
                state_d   = ADDR;
                is_read_d = 1'b1;
              end else if (byte_in == OP_WRITE) begin
                state_d   = ADDR;
                is_read_d = 1'b0;
`ifdef SPI_RESP_WEL_EN
              end else if (byte_in == OPC_RDSR) begin
                state_d   = STATUS;
`endif
              end else begin
                state_d   = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          // Shifting straight into the RAM address lets the unused upper
          // address bits fall off the top.
          if (sck_rise) begin
            addr_d    = {addr_q[ADDRESS_WIDTH-2:0], mosi_sync};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
              bit_cnt_d = 5'd0;
              if (is_read_q) begin
                re_d    = 1'b1;
                state_d = RDATA;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA, STATUS: begin
          // The fall that opens a byte loads it; the remaining falls shift.
          if (sck_fall) begin
            if (bit_cnt_q == 5'd0) begin
              tx_shift_d = tx_src;
              miso_d     = tx_src[7];
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              miso_d     = tx_shift_q[6];
            end
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if (state_q == RDATA) begin
                addr_d = addr_q + 1'b1;
                re_d   = 1'b1;
              end
            end
          end
        end
        WDATA: begin
          if (sck_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = 5'd0;
              wdata_d    = byte_in;
              we_d       = write_ok;
              inc_pend_d = 1'b1;
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All protocol state and registered outputs.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 8'h00;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      tx_buf_q   <= 8'h00;
      tx_shift_q <= 8'h00;
      miso_q     <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      rd_pend_q  <= 1'b0;
      inc_pend_q <= 1'b0;
`ifdef SPI_RESP_WEL_EN
      wel_q      <= 1'b0;
      op_q       <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
      re_q       <= re_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_pend_q  <= rd_pend_d;
      inc_pend_q <= inc_pend_d;
`ifdef SPI_RESP_WEL_EN
      wel_q      <= wel_d;
      op_q       <= op_d;
`endif
    end
  end

  assign spi_miso    = miso_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_ram_we    = we_q;
  assign o_ram_re    = re_q;

endmodule
